servo_pwm_multi: RTL and testbench

Multi-channel servo PWM generator. It generalises the single-channel 8-bit servo driver to NCH channels sharing one period counter, with a configurable period and pulse width. Each channel has its pulse width clamped to [MIN_PW, MAX_PW] and slew-limited by STEP counts per period. New targets arrive over a valid/ready write port from the sensor/control logic, and channels update only at period boundaries, so there are no glitched pulses.

---
 rtl/servo_pwm_multi_if.sv | 16 +
 rtl/servo_pwm_multi.sv | 122 ++++++++++++
 tb/tb_servo_pwm_multi.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/servo_pwm_multi_if.sv
// Write port carrying new per-channel pulse-width targets into servo_pwm_multi.
// The master drives a request and the slave (servo_pwm_multi) answers with wr_ready.
interface servo_pwm_multi_if #(
  parameter int NCH    = 4,
  parameter int DUTY_W = 12
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic              wr_valid;
  logic              wr_ready;
  logic [CH_W-1:0]   wr_ch;
  logic [DUTY_W-1:0] wr_pw;

  modport master (output wr_valid, output wr_ch, output wr_pw, input wr_ready);
  modport slave  (input wr_valid, input wr_ch, input wr_pw, output wr_ready);
endinterface

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM: one shared period counter, per-channel clamped targets,
// slew-limited applied widths that only change at period boundaries.
module servo_pwm_multi #(
  parameter int NCH      = 4,
  parameter int CNT_W    = 12,
  parameter int PERIOD   = 1000,
  parameter int DUTY_W   = 12,
  parameter int MIN_PW   = 50,
  parameter int MAX_PW   = 100,
  parameter int STEP     = 4,
  parameter int RESET_PW = 75
) (
  input  logic               clkin,
  input  logic               rstn,
  input  logic               en,
  servo_pwm_multi_if.slave   wr,
  output logic [NCH-1:0]     pwmout,
  output logic               period_start,
  output logic [NCH-1:0]     slewing
);

  localparam int XW    = DUTY_W + 1;
  localparam int CMP_W = (CNT_W > DUTY_W) ? CNT_W : DUTY_W;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [XW-1:0]     MIN_X    = XW'(MIN_PW);
  localparam logic [XW-1:0]     MAX_X    = XW'(MAX_PW);
  localparam logic [XW-1:0]     STEP_X   = XW'(STEP);
  localparam logic [DUTY_W-1:0] RST_W    = DUTY_W'(RESET_PW);

  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [NCH-1:0][DUTY_W-1:0]   tgt_q, tgt_d;
  logic [NCH-1:0][DUTY_W-1:0]   cur_q, cur_d;
  logic [NCH-1:0]               pwm_q, pwm_d;
  logic                         ps_q, ps_d;
  logic [NCH-1:0]               slew_q, slew_d;

  logic                         boundary;
  logic                         wr_ready_s;
  logic                         accept;
  logic [XW-1:0]                pw_x;
  logic [DUTY_W-1:0]            pw_clamp;

  // Counter and write port; the boundary cycle blocks writes so tgt is stable for the slew step.
  always_comb begin
    boundary   = en && (cnt_q == CNT_LAST);
    wr_ready_s = !rstn && !boundary;
    accept     = wr.wr_valid && wr_ready_s;
    cnt_d      = (en && !boundary) ? cnt_q + CNT_W'(1) : '0;

    pw_x = XW'(wr.wr_pw);
    if (pw_x < MIN_X) begin
      pw_clamp = DUTY_W'(MIN_X);
    end else if (pw_x > MAX_X) begin
      pw_clamp = DUTY_W'(MAX_X);
    end else begin
      pw_clamp = wr.wr_pw;
    end

    tgt_d = tgt_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (accept && (32'(wr.wr_ch) == i)) begin
        tgt_d[i] = pw_clamp;
      end
    end
  end

  assign wr.wr_ready = wr_ready_s;

  // Slew step at DUTY_W+1 bits; a step that would pass the target lands exactly on it.
  always_comb begin
    logic [XW-1:0] t_x;
    logic [XW-1:0] c_x;
    cur_d = cur_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      t_x = XW'(tgt_q[i]);
      c_x = XW'(cur_q[i]);
      if (boundary) begin
        if (STEP == 0) begin
          cur_d[i] = tgt_q[i];
        end else if (t_x > c_x) begin
          cur_d[i] = ((t_x - c_x) > STEP_X) ? DUTY_W'(c_x + STEP_X) : tgt_q[i];
        end else if (t_x < c_x) begin
          cur_d[i] = ((c_x - t_x) > STEP_X) ? DUTY_W'(c_x - STEP_X) : tgt_q[i];
        end
      end
    end
  end

  always_comb begin
    pwm_d  = '0;
    slew_d = '0;
    ps_d   = en && (cnt_q == '0);
    for (int unsigned i = 0; i < NCH; i++) begin
      pwm_d[i]  = en && (CMP_W'(cnt_q) < CMP_W'(cur_q[i]));
      slew_d[i] = (cur_q[i] != tgt_q[i]);
    end
  end

  always_ff @(posedge clkin or posedge rstn) begin
    if (rstn) begin
      cnt_q  <= '0;
      tgt_q  <= {NCH{RST_W}};
      cur_q  <= {NCH{RST_W}};
      pwm_q  <= '0;
      ps_q   <= 1'b0;
      slew_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      tgt_q  <= tgt_d;
      cur_q  <= cur_d;
      pwm_q  <= pwm_d;
      ps_q   <= ps_d;
      slew_q <= slew_d;
    end
  end

  assign pwmout       = pwm_q;
  assign period_start = ps_q;
  assign slewing      = slew_q;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Scoreboard bench for servo_pwm_multi: two instances (STEP=3 and STEP=0) sharing clock,
// reset and enable; the monitor measures each complete period and pops expected widths.
module tb_servo_pwm_multi;

  // Three channels so an out-of-range index (3) is representable on wr_ch.
  localparam int NCH    = 3;
  localparam int CNT_W  = 12;
  localparam int PERIOD = 20;
  localparam int DUTY_W = 12;

  typedef struct packed {
    logic [NCH-1:0]             slew;
    logic [NCH-1:0][DUTY_W-1:0] w;
  } exp_t;

  logic           clkin = 1'b0;
  logic           rstn;
  logic           en;
  logic [NCH-1:0] pwm_a, pwm_b, sl_a, sl_b;
  logic           ps_a, ps_b;

  int total = 0;
  int bad   = 0;

  exp_t        q_a[$];
  exp_t        q_b[$];
  int unsigned mcyc[2];
  bit          mseen[2];
  int unsigned mhi[2][NCH];
  logic [NCH-1:0] mslew[2];

  servo_pwm_multi_if #(.NCH(NCH), .DUTY_W(DUTY_W)) ifa ();
  servo_pwm_multi_if #(.NCH(NCH), .DUTY_W(DUTY_W)) ifb ();

  servo_pwm_multi #(
    .NCH(NCH), .CNT_W(CNT_W), .PERIOD(PERIOD), .DUTY_W(DUTY_W),
    .MIN_PW(2), .MAX_PW(16), .STEP(3), .RESET_PW(5)
  ) dut_a (
    .clkin(clkin), .rstn(rstn), .en(en), .wr(ifa.slave),
    .pwmout(pwm_a), .period_start(ps_a), .slewing(sl_a)
  );

  servo_pwm_multi #(
    .NCH(NCH), .CNT_W(CNT_W), .PERIOD(PERIOD), .DUTY_W(DUTY_W),
    .MIN_PW(2), .MAX_PW(16), .STEP(0), .RESET_PW(5)
  ) dut_b (
    .clkin(clkin), .rstn(rstn), .en(en), .wr(ifb.slave),
    .pwmout(pwm_b), .period_start(ps_b), .slewing(sl_b)
  );

  always #5 clkin = ~clkin;

  task automatic chk(input string name, input int unsigned act, input int unsigned want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  function automatic exp_t mk(input int unsigned w0, input int unsigned w1,
                              input int unsigned w2, input logic [NCH-1:0] s);
    exp_t e;
    e.slew = s;
    e.w[0] = DUTY_W'(w0);
    e.w[1] = DUTY_W'(w1);
    e.w[2] = DUTY_W'(w2);
    return e;
  endfunction

  task automatic push(input exp_t ea, input exp_t eb);
    q_a.push_back(ea);
    q_b.push_back(eb);
  endtask

  task automatic monitor();
    logic [NCH-1:0] pw;
    logic [NCH-1:0] sl;
    logic           ps;
    exp_t           e;
    bit             got;
    forever begin
      @(negedge clkin);
      for (int d = 0; d < 2; d++) begin
        pw = (d == 0) ? pwm_a : pwm_b;
        sl = (d == 0) ? sl_a  : sl_b;
        ps = (d == 0) ? ps_a  : ps_b;
        if (rstn || !en) begin
          mseen[d] = 1'b0;
        end else begin
          if (ps) begin
            if (mseen[d]) begin
              if (mcyc[d] != PERIOD) begin
                total++;
                bad++;
                $display("FAIL dut%0d_period_len: got %0d expected %0d", d, mcyc[d], PERIOD);
              end else begin
                got = 1'b0;
                if (d == 0 && q_a.size() > 0) begin
                  e = q_a.pop_front();
                  got = 1'b1;
                end else if (d == 1 && q_b.size() > 0) begin
                  e = q_b.pop_front();
                  got = 1'b1;
                end
                if (got) begin
                  for (int ch = 0; ch < NCH; ch++) begin
                    chk($sformatf("dut%0d_width_ch%0d", d, ch), mhi[d][ch], int'(e.w[ch]));
                  end
                  chk($sformatf("dut%0d_slewing", d), int'(mslew[d]), int'(e.slew));
                end else begin
                  total++;
                  bad++;
                  $display("FAIL dut%0d_unexpected_period: got extra period expected none", d);
                end
              end
            end
            mseen[d] = 1'b1;
            mcyc[d]  = 0;
            mslew[d] = sl;
            for (int ch = 0; ch < NCH; ch++) mhi[d][ch] = 0;
          end
          if (mseen[d]) begin
            mcyc[d]++;
            for (int ch = 0; ch < NCH; ch++) mhi[d][ch] += int'(pw[ch]);
          end
        end
      end
    end
  endtask

  task automatic next_start();
    bit ok = 1'b0;
    for (int n = 0; n < 4 * PERIOD; n++) begin
      @(negedge clkin);
      if (ps_a) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL start_timeout: got no period_start expected one within %0d cycles", 4 * PERIOD);
    end
  endtask

  task automatic do_wr(input bit b, input int unsigned ch, input int unsigned pw);
    bit ok = 1'b0;
    if (b) begin
      ifb.wr_valid = 1'b1; ifb.wr_ch = ch[1:0]; ifb.wr_pw = pw[DUTY_W-1:0];
    end else begin
      ifa.wr_valid = 1'b1; ifa.wr_ch = ch[1:0]; ifa.wr_pw = pw[DUTY_W-1:0];
    end
    for (int n = 0; n < 2 * PERIOD; n++) begin
      #1;
      if ((b ? ifb.wr_ready : ifa.wr_ready) == 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clkin);
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL write_timeout: got wr_ready=0 expected 1 within %0d cycles", 2 * PERIOD);
    end
    @(negedge clkin);
    if (b) ifb.wr_valid = 1'b0;
    else   ifa.wr_valid = 1'b0;
  endtask

  initial begin
    rstn = 1'b1;
    en   = 1'b1;
    ifa.wr_valid = 1'b0; ifa.wr_ch = '0; ifa.wr_pw = '0;
    ifb.wr_valid = 1'b0; ifb.wr_ch = '0; ifb.wr_pw = '0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clkin);
    chk("rst_pwm_a", pwm_a, 0);
    chk("rst_pwm_b", pwm_b, 0);
    chk("rst_ps_a", ps_a, 0);
    chk("rst_slew_a", sl_a, 0);
    chk("rst_ready_a", ifa.wr_ready, 0);
    chk("rst_ready_b", ifb.wr_ready, 0);
    rstn = 1'b0;

    // P1: reset widths; A ch0 slews toward 14, B ch0 jumps to 16
    next_start();
    push(mk(5, 5, 5, 3'b000), mk(5, 5, 5, 3'b000));
    do_wr(1'b0, 0, 14);
    do_wr(1'b1, 0, 16);

    // P2: clamp 30->16 then overwrite with 1->2; index 3 is discarded
    next_start();
    push(mk(8, 5, 5, 3'b001), mk(16, 5, 5, 3'b000));
    do_wr(1'b0, 1, 30);
    do_wr(1'b0, 1, 1);
    do_wr(1'b0, 3, 10);

    // P3: hold a request across the boundary cycle
    next_start();
    push(mk(11, 2, 5, 3'b001), mk(16, 5, 5, 3'b000));
    repeat (PERIOD - 2) @(negedge clkin);
    ifa.wr_valid = 1'b1; ifa.wr_ch = 2'd2; ifa.wr_pw = 12'd9;
    #1 chk("boundary_ready", ifa.wr_ready, 0);
    @(negedge clkin);
    #1 chk("post_boundary_ready", ifa.wr_ready, 1);

    next_start();
    push(mk(14, 2, 5, 3'b000), mk(16, 5, 5, 3'b000));
    ifa.wr_valid = 1'b0;

    next_start();
    push(mk(14, 2, 8, 3'b100), mk(16, 5, 5, 3'b000));
    next_start();
    push(mk(14, 2, 9, 3'b000), mk(16, 5, 5, 3'b000));

    // P7: enable dropped mid-pulse, then restarted
    next_start();
    repeat (2) @(negedge clkin);
    en = 1'b0;
    @(negedge clkin);
    chk("en_off_pwm_a", pwm_a, 0);
    chk("en_off_pwm_b", pwm_b, 0);
    for (int n = 0; n < 5; n++) begin
      @(negedge clkin);
      chk("en_off_ps", ps_a, 0);
      chk("en_off_ready", ifa.wr_ready, 1);
    end
    en = 1'b1;
    @(negedge clkin);
    chk("restart_ps", ps_a, 1);
    push(mk(14, 2, 9, 3'b000), mk(16, 5, 5, 3'b000));

    // P9: asynchronous reset mid-pulse
    next_start();
    repeat (2) @(negedge clkin);
    #2;
    chk("pre_reset_pwm_a0", pwm_a[0], 1);
    chk("pre_reset_pwm_b0", pwm_b[0], 1);
    rstn = 1'b1;
    #1;
    chk("async_rst_pwm_a", pwm_a, 0);
    chk("async_rst_pwm_b", pwm_b, 0);
    chk("async_rst_slew_a", sl_a, 0);
    chk("async_rst_ready_a", ifa.wr_ready, 0);
    repeat (3) @(negedge clkin);
    rstn = 1'b0;

    next_start();
    push(mk(5, 5, 5, 3'b000), mk(5, 5, 5, 3'b000));
    next_start();
    @(negedge clkin);
    chk("leftover_a", q_a.size(), 0);
    chk("leftover_b", q_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
